// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// counter sizing and the divide-by-zero quotient constant.
package div_pkg;

    // State encoding for the divider FSM (IDLE -> RUN -> DONE -> IDLE).
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [31:0] dbz_quotient(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The trial result always lies in (-2^WIDTH, 2^WIDTH), so its MSB is an exact sign.
    assign shifted = {rem_in, dvd_bit};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = ~trial[WIDTH];
    assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_nbit.sv
// WIDTH-bit multi-cycle restoring divider with start/done handshake and
// divide-by-zero flag; define DIV_SIGNED_EN to add two's-complement operation.
module seq_divider_nbit
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sign_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW      = cnt_width(WIDTH);
    localparam logic [31:0]     DBZ_ALL = dbz_quotient(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_Q  = DBZ_ALL[WIDTH-1:0];

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             run_last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_final, r_final;

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d;
    logic a_neg, b_neg;

    // Magnitudes feed the unsigned core; signs are reapplied when results are registered.
    assign a_neg   = sign_mode & dividend[WIDTH-1];
    assign b_neg   = sign_mode & divisor[WIDTH-1];
    assign a_mag   = a_neg ? -dividend : dividend;
    assign b_mag   = b_neg ? -divisor : divisor;
    assign q_final = zdiv_q ? DBZ_Q : (qneg_q ? -work_q : work_q);
    assign r_final = zdiv_q ? (rneg_q ? -work_q : work_q) : (rneg_q ? -rem_q : rem_q);
`else
    logic unused_sign_mode;

    assign unused_sign_mode = sign_mode;
    assign a_mag   = dividend;
    assign b_mag   = divisor;
    assign q_final = zdiv_q ? DBZ_Q : work_q;
    assign r_final = zdiv_q ? work_q : rem_q;
`endif

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (work_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    // A zero divisor skips the iterations but keeps the two-cycle RUN dwell.
    assign run_last = zdiv_q ? (cnt_q == CW'(1)) : (cnt_q == CW'(WIDTH));

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        work_d      = work_q;
        dsr_d       = dsr_q;
        zdiv_d      = zdiv_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    work_d  = a_mag;
                    dsr_d   = b_mag;
                    zdiv_d  = (divisor == '0);
`ifdef DIV_SIGNED_EN
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
`endif
                end
            end
            RUN: begin
                if (run_last) begin
                    state_d     = DONE;
                    quotient_d  = q_final;
                    remainder_d = r_final;
                    dbz_d       = zdiv_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!zdiv_q) begin
                        rem_d  = step_rem;
                        work_d = {work_q[WIDTH-2:0], step_qbit};
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            work_q      <= '0;
            dsr_q       <= '0;
            zdiv_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            work_q      <= work_d;
            dsr_q       <= dsr_d;
            zdiv_q      <= zdiv_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
